// File: rtl/mux4_3_sel_pkg.sv
// Shared constants and helpers for the N-way lane selector.
package mux_pkg;

    localparam int unsigned MUX_N_INPUTS = 4;
    localparam int unsigned MUX_WIDTH    = 3;

    // Select width for n lanes; never below one bit so a 2:1 tree still has a level.
    function automatic int unsigned mux_sel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux4_3_sel_if.sv
// Lane bus, select and result signals of the N-way selector.
interface mux4_3_sel_if
    import mux_pkg::*;
#(
    parameter int unsigned N_INPUTS = MUX_N_INPUTS,
    parameter int unsigned WIDTH    = MUX_WIDTH
);
    localparam int unsigned SEL_W = mux_sel_w(N_INPUTS);

    logic [N_INPUTS*WIDTH-1:0] a;
    logic [SEL_W-1:0]          s;
    logic [WIDTH-1:0]          y;
    logic [WIDTH-1:0]          y_q;

    modport master (output a, output s, input y, input y_q);
    modport slave  (input a, input s, output y, output y_q);

endinterface

// File: rtl/mux4_3_sel_mux2_w.sv
// WIDTH-bit 2:1 selector, the leaf cell of the selection tree.
module mux2_w #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y_c
);

    // Pick d1 when the select bit is set, otherwise d0.
    assign o_y_c = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux4_3_sel.sv
// N-way, WIDTH-bit lane selector: combinational y plus a registered copy y_q.
module mux4_3_sel
    import mux_pkg::*;
#(
    parameter int unsigned N_INPUTS = MUX_N_INPUTS,
    parameter int unsigned WIDTH    = MUX_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mux4_3_sel_if.slave   bus
);

    localparam int unsigned SEL_W  = mux_sel_w(N_INPUTS);
    localparam int unsigned LEAVES = 1 << SEL_W;
    localparam int unsigned NODES  = 2 * LEAVES - 1;

    // Heap-ordered tree: node 0 is the root, leaves occupy the last LEAVES slots.
    // A node at level l (leaves at level 0) in position j lives at (LEAVES>>l)-1+j.
    logic [WIDTH-1:0] w_tree [NODES];
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;

    // Leaves: real lanes, with padding leaves forced to zero so s >= N_INPUTS yields 0.
    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        if (k < N_INPUTS) begin : g_lane
            assign w_tree[LEAVES - 1 + k] = bus.a[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_tree[LEAVES - 1 + k] = '0;
        end
    end

    // Internal levels: level lvl+1 merges pairs from level lvl using select bit s[lvl].
    for (genvar lvl = 0; lvl < SEL_W; lvl++) begin : g_level
        for (genvar j = 0; j < (LEAVES >> (lvl + 1)); j++) begin : g_node
            mux2_w #(
                .WIDTH (WIDTH)
            ) u_mux2 (
                .i_d0  (w_tree[(LEAVES >> lvl) - 1 + 2*j]),
                .i_d1  (w_tree[(LEAVES >> lvl) - 1 + 2*j + 1]),
                .i_sel (bus.s[lvl]),
                .o_y_c (w_tree[(LEAVES >> (lvl + 1)) - 1 + j])
            );
        end
    end

    assign w_y   = w_tree[0];
    assign bus.y = w_y;

    // Pipelined copy of the selected lane; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q <= '0;
        end else begin
            r_y_q <= w_y;
        end
    end

    assign bus.y_q = r_y_q;

endmodule

// File: tb/tb_mux4_3_sel.sv
// Self-checking bench for mux4_3_sel: default 4x3 build plus a 3x4 variant.
module tb_mux4_3_sel;

    logic clk;
    logic rst;

    int checks;
    int failures;

    mux4_3_sel_if #(.N_INPUTS(4), .WIDTH(3)) bus0 ();
    mux4_3_sel_if #(.N_INPUTS(3), .WIDTH(4)) bus1 ();

    mux4_3_sel #(.N_INPUTS(4), .WIDTH(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    mux4_3_sel #(.N_INPUTS(3), .WIDTH(4)) u_dut_var (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [1:0]  s;
        logic [2:0]  y;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t        vecs [8];
        logic [11:0] ra;
        logic [1:0]  rs;
        logic [2:0]  model;
        int          rand_bad;

        checks   = 0;
        failures = 0;

        // Directed lanes, then lane isolation.
        vecs[0] = '{12'b101_011_110_001, 2'd0, 3'b001};
        vecs[1] = '{12'b101_011_110_001, 2'd1, 3'b110};
        vecs[2] = '{12'b101_011_110_001, 2'd2, 3'b011};
        vecs[3] = '{12'b101_011_110_001, 2'd3, 3'b101};
        vecs[4] = '{12'b111_000_000_000, 2'd0, 3'b000};
        vecs[5] = '{12'b111_000_000_000, 2'd1, 3'b000};
        vecs[6] = '{12'b111_000_000_000, 2'd2, 3'b000};
        vecs[7] = '{12'b111_000_000_000, 2'd3, 3'b111};

        // Reset sequence: y stays live, y_q held at zero.
        rst     = 1'b1;
        bus0.a  = 12'hFFF;
        bus0.s  = 2'd3;
        bus1.a  = 12'hABC;
        bus1.s  = 2'd2;
        #1;
        check("rst_y_live_pre", 32'(bus0.y), 32'h7);
        @(posedge clk); #1;
        check("rst_yq_edge1", 32'(bus0.y_q), 32'h0);
        check("rst_y_live_1", 32'(bus0.y), 32'h7);
        check("rst_var_yq", 32'(bus1.y_q), 32'h0);
        @(posedge clk); #1;
        check("rst_yq_edge2", 32'(bus0.y_q), 32'h0);
        check("rst_y_live_2", 32'(bus0.y), 32'h7);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_yq", 32'(bus0.y_q), 32'h7);
        check("var_yq_after_rst", 32'(bus1.y_q), 32'hA);

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            bus0.a = vecs[i].a;
            bus0.s = vecs[i].s;
            #1;
            check($sformatf("vec%0d_y", i), 32'(bus0.y), 32'(vecs[i].y));
        end

        // Toggling unselected lanes while s=3 must not disturb y.
        bus0.s = 2'd3;
        for (int i = 0; i < 4; i++) begin
            bus0.a = {3'b111, 9'(i * 9'h0A5 + 9'h1FF * (i & 1))};
            #1;
            check($sformatf("iso_toggle%0d", i), 32'(bus0.y), 32'h7);
        end

        // Random sweep against a behavioural lane model.
        rand_bad = 0;
        for (int i = 0; i < 1024; i++) begin
            ra = 12'($urandom);
            rs = 2'($urandom);
            bus0.a = ra;
            bus0.s = rs;
            #1;
            model = ra[rs*3 +: 3];
            if (bus0.y !== model) begin
                rand_bad++;
                if (rand_bad <= 4)
                    $display("FAIL rand_y: a=%h s=%0d got %b expected %b", ra, rs, bus0.y, model);
            end
        end
        check("rand_sweep_mismatches", 32'(rand_bad), 32'h0);

        // Register latency: y moves at once, y_q waits for the next edge.
        @(negedge clk);
        bus0.a = 12'b101_011_110_001;
        bus0.s = 2'd0;
        @(posedge clk); #1;
        check("lat_yq_s0", 32'(bus0.y_q), 32'h1);
        bus0.s = 2'd3;
        #1;
        check("lat_y_now", 32'(bus0.y), 32'h5);
        check("lat_yq_hold", 32'(bus0.y_q), 32'h1);
        @(posedge clk); #1;
        check("lat_yq_next", 32'(bus0.y_q), 32'h5);

        // Non-power-of-two variant: padding select gives zero.
        bus1.a = 12'hABC;
        bus1.s = 2'd3;
        #1;
        check("var_s3_zero", 32'(bus1.y), 32'h0);
        bus1.s = 2'd2;
        #1;
        check("var_s2", 32'(bus1.y), 32'hA);
        bus1.s = 2'd1;
        #1;
        check("var_s1", 32'(bus1.y), 32'hB);
        bus1.s = 2'd0;
        #1;
        check("var_s0", 32'(bus1.y), 32'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_3_sel.md
Name: mux4_3_sel

Overview:
- Parameterised W-bit, N-way selector; default configuration is 4 inputs of 3 bits each.
- Inputs arrive as one flat packed bus; a binary select picks one lane.
- Primary output y is purely combinational. A registered copy y_q is provided for pipelined consumers.
- Used as a leaf selector inside the ALU datapath.

Parameters:
- N_INPUTS, 4, number of selectable lanes (>=2).
- WIDTH, 3, bit width of each lane.
- SEL_W, $clog2(N_INPUTS), select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; used only by y_q.
- rst  input  1  synchronous, active-high reset; clears y_q.
- a  input  N_INPUTS*WIDTH (12)  packed lanes; lane k occupies a[k*WIDTH +: WIDTH]; lane 0 in the LSBs.
- s  input  SEL_W (2)  binary lane select.
- y  output  WIDTH (3)  combinational selected lane.
- y_q  output  WIDTH (3)  y registered on clk.

Behaviour:
- y = a[s*WIDTH +: WIDTH] when s < N_INPUTS. Zero latency, with no clock dependency. Must settle within 1 ns of a change on a or s in simulation.
- Default mapping:
  - s=0 -> a[2:0]
  - s=1 -> a[5:3]
  - s=2 -> a[8:6]
  - s=3 -> a[11:9]
- s >= N_INPUTS (reachable only when N_INPUTS is not a power of 2): y = all zeros.
- Output is 4-state clean: fully defined a and s give a fully defined y, with no X or Z.
- Unselected lanes never affect y.
- y_q:
  - On each rising clk edge, y_q <= y.
  - If rst=1 at the edge, y_q <= 0 instead; reset has priority.
  - One-cycle latency from y.
  - y_q stays 0 for every edge at which rst is held high.
- rst does not affect y. The combinational path stays live during reset.
- The block contains no other state, no handshake and no enables.

Decomposition:
- Shared package mux_pkg holds:
  - default constants MUX_N_INPUTS=4 and MUX_WIDTH=3;
  - the localparam function computing SEL_W.
- One sub-module, mux2_w:
  - a WIDTH-bit 2:1 selector;
  - instantiated in a generate-built binary tree of depth SEL_W, driven by select bit s[level];
  - out-of-range padding leaves are tied to zero.
- The output register is inline in the top module.

Test Plan:
- Directed lanes: a=12'b101_011_110_001, s = 0,1,2,3 -> y = 001, 110, 011, 101 respectively, each after #1.
- Lane isolation: a=12'b111_000_000_000, s=0..2 -> y=000; s=3 -> y=111. Toggling a[8:0] while s=3 leaves y=111.
- Random sweep: 1024 iterations of random a (12 bits) and random s (2 bits). y must match behavioural model a[s*3 +: 3] using === on every change of a or s. Zero mismatches required.
- Reset: rst=1 for 2 edges with a=12'hFFF, s=3 -> y_q=000 after first edge, y=111 throughout. Deassert rst -> y_q=111 after next edge.
- Register latency: rst=0, a=12'b101_011_110_001, switch s from 0 to 3 between edges -> y changes immediately to 101; y_q shows 001 until the next rising edge, then 101.
- Parameter variant: N_INPUTS=3, WIDTH=4, s=3 -> y=0000; s=2 -> y=a[11:8].
